axis_rgb_packer: RTL and testbench
==================================

Name: axis_rgb_packer

Overview:
- Transmit end of the video AXI-Stream link: accepts one 24-bit RGB pixel per handshake from the pixel compute pipeline.
- Packs every 4 pixels into 3 32-bit words and drives out_stream_* towards the VDMA or frame checker.
- Generates tuser (SOF) on the first word of each frame and tlast (EOL) on the last word of each line.
- Supports resynchronisation when the pipeline flags a new frame mid-frame.

Parameters:
X_PIXELS, 640, pixels per line; must be a multiple of 4 (X_WORDS = X_PIXELS*3/4 = 480)
Y_SIZE, 480, lines per frame

Ports:
out_stream_aclk  in  1  single clock for all logic
periph_resetn  in  1  reset, synchronous, active-low
pix_valid  in  1  input pixel valid
pix_ready  out  1  input pixel ready
pix_r  in  8  red
pix_g  in  8  green
pix_b  in  8  blue
pix_sof  in  1  pixel is first of a frame (sampled only on handshake)
out_stream_tdata  out  32  packed bytes
out_stream_tkeep  out  4  constant 4'hF
out_stream_tvalid  out  1  word valid
out_stream_tready  in  1  downstream ready
out_stream_tuser  out  1  SOF, first word of frame
out_stream_tlast  out  1  EOL, last word of line
err_resync  out  1  one-cycle pulse on unexpected pix_sof
frame_done  out  1  one-cycle pulse when last word of frame is accepted

Behaviour:
- Interface: one clock (out_stream_aclk); reset periph_resetn is synchronous and active-low.
- Reset state: tvalid, tuser, tlast, tdata, err_resync, frame_done = 0; tkeep = 4'hF; phase = 0; x_word = 0; y_line = 0; hold register = 0; pix_ready = 0 while reset is low.
- Byte stream order: S[3k]=R_k, S[3k+1]=G_k, S[3k+2]=B_k. Word w: tdata[8i+7:8i] = S[4w+i].
- Packing phase FSM (P0..P3, advances on each pixel handshake, P3 wraps to P0):
  - P0: store {B,G,R} of p0 in hold; no word emitted.
  - P1: emit {p1.R, p0.B, p0.G, p0.R}; hold p1 G,B.
  - P2: emit {p2.G, p2.R, p1.B, p1.G}; hold p2.B.
  - P3: emit {p3.B, p3.G, p3.R, p2.B}; hold empty.
- Output register: a single stage.
  - pix_ready = periph_resetn && (phase==P0 || !tvalid || tready). Combinational; no dependency on pix_valid.
  - A word becomes tvalid the cycle after the emitting pixel handshake (latency 1).
  - A simultaneous tready accept and new load sustains 1 word/cycle.
  - While tvalid && !tready: tdata, tuser, tlast held stable; tvalid never drops without a handshake.
- Position counters advance when a word is loaded into the output register:
  - tuser = (x_word==0 && y_line==0).
  - tlast = (x_word==X_WORDS-1).
  - x_word wraps to 0 and y_line increments; y_line wraps at Y_SIZE-1 to 0 (next frame).
- frame_done pulses the cycle after the handshake of the word carrying tlast on y_line Y_SIZE-1.
- Resync: a pix_sof handshake while (phase!=P0 || x_word!=0 || y_line!=0):
  - Discard hold bytes; set x_word = 0, y_line = 0; treat the pixel as P0 of a new frame.
  - Pulse err_resync the next cycle.
  - An already-loaded pending output word is unaffected and still delivered.
- pix_sof at the natural frame start: no action, no error.
- Missing pix_sof at frame start: no error; counters are authoritative.
- Reset mid-frame: takes effect next edge. Pending word and partial group are dropped; tvalid = 0 the next cycle regardless of tready.

Decomposition:
- Package axis_video_pkg:
  - typedef rgb_t (packed r,g,b 8 bits each);
  - enum pack_phase_t {P0,P1,P2,P3};
  - constant BYTES_PER_WORD = 4;
  - function words_per_line(x_pixels).
- The pixel generator and frame checker share this package.
- No sub-module; FSM, hold register, counters and output register live in one module (roughly 200 lines).

Test Plan (bench params X_PIXELS=8, Y_SIZE=2, X_WORDS=6):
1. tready=1, feed pixels k=0..15 with R=3k, G=3k+1, B=3k+2, pix_sof on k=0 -> 12 words with tdata bytes 0x00..0x2F ascending (word0=32'h03020100); tuser on word0 only; tlast on words 5 and 11; frame_done one cycle after word 11.
2. Same stream, tready toggling 1010… -> identical word sequence; tdata/tuser/tlast stable during every tready=0 cycle with tvalid=1; no pixel lost or duplicated.
3. tready=0 with tvalid=1 pending -> pix_ready=1 in P0, pix_ready=0 in P1..P3 until tready rises; then word accepted and next word loaded in the same cycle.
4. pix_sof on pixel 6 of line 0 (phase P2) -> err_resync pulses once; pending word delivered; next emitted word has tuser=1 and contains pixel 6 bytes in its low three bytes.
5. periph_resetn low for 1 cycle mid-line with tvalid=1, tready=0 -> tvalid=0 the next cycle; after release the first word carries tuser=1; phase restarts at P0.
6. Run 3 consecutive frames with RANDOM tready -> 3 frame_done pulses; tuser exactly once per frame; err_resync never asserts.

Source files
------------

// File: rtl/axis_video_pkg.sv
// Shared video-stream definitions for the RGB packer, the pixel generator and
// the frame checker.
//   rgb_t           : one 24-bit pixel (r, g, b)
//   pack_phase_t    : position of a pixel inside its 4-pixel / 3-word group
//   BYTES_PER_WORD  : bytes carried per output stream word
//   words_per_line  : output words produced by one line of x_pixels pixels
package axis_video_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {P0, P1, P2, P3} pack_phase_t;

    function automatic int words_per_line(input int x_pixels);
        return (x_pixels * 3) / BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/axis_rgb_packer_if.sv
// Bus bundles for the RGB packer.
//   pix_stream_if : pixel input (valid, ready, rgb, sof); master = pixel
//                   pipeline, slave = packer.
//   axis_video_if : 32-bit AXI-Stream video output (tdata, tkeep, tvalid,
//                   tready, tuser, tlast); master = packer, slave = VDMA or
//                   frame checker.
interface pix_stream_if;
    import axis_video_pkg::*;

    logic valid;
    logic ready;
    rgb_t rgb;
    logic sof;

    modport master (output valid, output rgb, output sof, input ready);
    modport slave  (input valid, input rgb, input sof, output ready);
endinterface

interface axis_video_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, output tkeep, output tvalid, output tuser,
                    output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tuser,
                    input tlast, output tready);
endinterface

// File: rtl/axis_rgb_packer.sv
// Transmit end of the video AXI-Stream link. Packs every 4 RGB pixels into
// 3 32-bit words (byte stream R0 G0 B0 R1 G1 B1 ..., lowest byte first),
// marks the first word of a frame with tuser and the last word of each line
// with tlast, and resynchronises on an unexpected pix_sof.
// Ports:
//   out_stream_aclk : clock for all logic
//   periph_resetn   : synchronous active-low reset
//   pix             : pixel input (slave)
//   out_stream      : packed AXI-Stream output (master), single register stage
//   err_resync      : one-cycle pulse after an unexpected pix_sof
//   frame_done      : one-cycle pulse after the last word of a frame is taken
module axis_rgb_packer
    import axis_video_pkg::*;
#(
    parameter int X_PIXELS = 640,
    parameter int Y_SIZE   = 480
) (
    input  logic          out_stream_aclk,
    input  logic          periph_resetn,
    pix_stream_if.slave   pix,
    axis_video_if.master  out_stream,
    output logic          err_resync,
    output logic          frame_done
);

    localparam int X_WORDS = words_per_line(X_PIXELS);
    localparam int XW_W    = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
    localparam int YW_W    = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW_W-1:0] X_LAST = XW_W'(X_WORDS - 1);
    localparam logic [YW_W-1:0] Y_LAST = YW_W'(Y_SIZE - 1);

    pack_phase_t     phase;
    logic [23:0]     hold;
    logic [XW_W-1:0] x_word;
    logic [YW_W-1:0] y_line;

    logic [31:0]     tdata;
    logic            tvalid;
    logic            tuser;
    logic            tlast;
    logic            word_eof;   // word in the output register ends the frame

    logic            pix_ready;
    logic            pix_hs;
    logic            out_hs;
    logic            resync;
    logic            load;
    logic [31:0]     word;
    rgb_t            p;

    assign out_stream.tdata  = tdata;
    assign out_stream.tkeep  = 4'hF;
    assign out_stream.tvalid = tvalid;
    assign out_stream.tuser  = tuser;
    assign out_stream.tlast  = tlast;
    assign pix.ready         = pix_ready;
    assign p                 = pix.rgb;

    // P0 never emits a word, so it can accept a pixel even while the output
    // register is stalled.
    assign pix_ready = periph_resetn &&
                       (phase == P0 || !tvalid || out_stream.tready);
    assign pix_hs    = pix.valid && pix_ready;
    assign out_hs    = tvalid && out_stream.tready;

    // A sof anywhere other than the natural frame origin restarts the frame;
    // the pixel then behaves as P0 and emits nothing.
    assign resync = pix_hs && pix.sof &&
                    (phase != P0 || x_word != '0 || y_line != '0);
    assign load   = pix_hs && !resync && phase != P0;

    // hold keeps leftover bytes right-aligned in stream order.
    always_comb begin
        word = '0;
        case (phase)
            P1:      word = {p.r, hold[23:0]};
            P2:      word = {p.g, p.r, hold[15:0]};
            P3:      word = {p.b, p.g, p.r, hold[7:0]};
            default: word = '0;
        endcase
    end

    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            phase      <= P0;
            hold       <= '0;
            x_word     <= '0;
            y_line     <= '0;
            tdata      <= '0;
            tvalid     <= 1'b0;
            tuser      <= 1'b0;
            tlast      <= 1'b0;
            word_eof   <= 1'b0;
            err_resync <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            err_resync <= resync;
            frame_done <= out_hs && word_eof;

            if (pix_hs) begin
                if (resync || phase == P0) begin
                    hold  <= {p.b, p.g, p.r};
                    phase <= P1;
                end else begin
                    case (phase)
                        P1: begin
                            hold  <= {8'h00, p.b, p.g};
                            phase <= P2;
                        end
                        P2: begin
                            hold  <= {16'h0000, p.b};
                            phase <= P3;
                        end
                        default: begin
                            hold  <= '0;
                            phase <= P0;
                        end
                    endcase
                end
            end

            if (load) begin
                tdata    <= word;
                tvalid   <= 1'b1;
                tuser    <= (x_word == '0) && (y_line == '0);
                tlast    <= (x_word == X_LAST);
                word_eof <= (x_word == X_LAST) && (y_line == Y_LAST);
            end else if (out_hs) begin
                tvalid <= 1'b0;
            end

            if (resync) begin
                x_word <= '0;
                y_line <= '0;
            end else if (load) begin
                if (x_word == X_LAST) begin
                    x_word <= '0;
                    y_line <= (y_line == Y_LAST) ? '0 : y_line + 1'b1;
                end else begin
                    x_word <= x_word + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_rgb_packer.sv
// Randomised bench for axis_rgb_packer (X_PIXELS=8, Y_SIZE=2). A byte-stream
// scoreboard predicts every output word, its tuser/tlast, the resync and
// frame_done pulses, and the expected pix_ready / tvalid each cycle.
module tb_axis_rgb_packer;
    import axis_video_pkg::*;

    localparam int XP      = 8;
    localparam int YS      = 2;
    localparam int XW      = XP * 3 / 4;
    localparam int FRAME_W = XW * YS;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
        logic        eof;
    } exp_t;

    typedef struct {
        rgb_t c;
        logic sof;
    } pixd_t;

    logic clk = 1'b0;
    logic rst_n;
    logic err_resync;
    logic frame_done;

    pix_stream_if pix ();
    axis_video_if axs ();

    axis_rgb_packer #(.X_PIXELS(XP), .Y_SIZE(YS)) dut (
        .out_stream_aclk (clk),
        .periph_resetn   (rst_n),
        .pix             (pix),
        .out_stream      (axs),
        .err_resync      (err_resync),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard state
    logic [7:0] bq[$];
    exp_t       exp_q[$];
    int         wcnt = 0;
    logic       err_pend = 1'b0;
    logic       fd_pend  = 1'b0;

    // stimulus state
    pixd_t pq[$];
    logic  pix_acc = 1'b0;
    int    rdy_mode = 0;   // 0 always, 1 toggle, 2 random, 3 held low
    logic  gaps = 1'b1;
    logic  armed = 1'b0;

    // observation counters
    int          n_words = 0, n_tuser = 0, n_fd = 0, n_err = 0;
    logic [31:0] first_word;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_user, prev_last;

    task automatic model_pixel(input rgb_t c, input logic sof);
        exp_t e;
        if (sof && (bq.size() != 0 || wcnt != 0)) begin
            bq.delete();
            wcnt = 0;
            err_pend = 1'b1;
        end
        bq.push_back(c.r);
        bq.push_back(c.g);
        bq.push_back(c.b);
        if (bq.size() >= 4) begin
            e.data = {bq[3], bq[2], bq[1], bq[0]};
            repeat (4) void'(bq.pop_front());
            e.user = (wcnt == 0);
            e.last = (wcnt % XW) == XW - 1;
            e.eof  = (wcnt == FRAME_W - 1);
            wcnt   = (wcnt + 1) % FRAME_W;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("tvalid", 32'(axs.tvalid), 32'(exp_q.size() != 0));
            if (axs.tvalid && exp_q.size() != 0) begin
                chk("tdata", axs.tdata, exp_q[0].data);
                chk("tuser", 32'(axs.tuser), 32'(exp_q[0].user));
                chk("tlast", 32'(axs.tlast), 32'(exp_q[0].last));
            end
            chk("tkeep", 32'(axs.tkeep), 32'hF);
            chk("pix_ready", 32'(pix.ready),
                32'(rst_n && (bq.size() == 0 || exp_q.size() == 0 || axs.tready)));
            chk("err_resync", 32'(err_resync), 32'(err_pend));
            chk("frame_done", 32'(frame_done), 32'(fd_pend));
            if (prev_stall) begin
                chk("hold_tvalid", 32'(axs.tvalid), 32'd1);
                chk("hold_tdata", axs.tdata, prev_data);
                chk("hold_flags", {30'd0, axs.tuser, axs.tlast}, {30'd0, prev_user, prev_last});
            end
            if (frame_done) n_fd++;
            if (err_resync) n_err++;
        end

        err_pend   = 1'b0;
        fd_pend    = 1'b0;
        pix_acc    = 1'b0;
        prev_stall = rst_n && axs.tvalid && !axs.tready;
        prev_data  = axs.tdata;
        prev_user  = axs.tuser;
        prev_last  = axs.tlast;

        if (!rst_n) begin
            bq.delete();
            exp_q.delete();
            wcnt = 0;
        end else begin
            if (axs.tvalid && axs.tready) begin
                if (n_words == 0) first_word = axs.tdata;
                n_words++;
                if (axs.tuser) n_tuser++;
                if (exp_q.size() != 0) begin
                    fd_pend = exp_q[0].eof;
                    void'(exp_q.pop_front());
                end
            end
            if (pix.valid && pix.ready) begin
                pix_acc = 1'b1;
                model_pixel(pix.rgb, pix.sof);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (pix_acc && pq.size() != 0) void'(pq.pop_front());
        case (rdy_mode)
            0:       axs.tready = 1'b1;
            1:       axs.tready = ~axs.tready;
            2:       axs.tready = 1'($urandom_range(0, 1));
            default: axs.tready = 1'b0;
        endcase
        if (pix.valid && !pix_acc) begin
            // hold the offered pixel until it is taken
        end else if (pq.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            pix.valid = 1'b1;
            pix.rgb   = pq[0].c;
            pix.sof   = pq[0].sof;
        end else begin
            pix.valid = 1'b0;
            pix.sof   = 1'b0;
            pix.rgb   = rgb_t'($urandom);
        end
    endtask

    task automatic run_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (pq.size() == 0 && !pix.valid && exp_q.size() == 0) break;
        end
        chk("idle_timeout", 32'(i < budget), 32'd1);
        repeat (3) step();
    endtask

    task automatic clr_cnt();
        n_words = 0;
        n_tuser = 0;
        n_fd    = 0;
        n_err   = 0;
    endtask

    task automatic push_ramp();
        pixd_t d;
        for (int k = 0; k < 16; k++) begin
            d.c   = '{r: 8'(3 * k), g: 8'(3 * k + 1), b: 8'(3 * k + 2)};
            d.sof = (k == 0);
            pq.push_back(d);
        end
    endtask

    task automatic push_rand(input int n, input logic sof_first);
        pixd_t d;
        for (int k = 0; k < n; k++) begin
            d.c   = rgb_t'($urandom);
            d.sof = sof_first && (k % (XP * YS) == 0);
            pq.push_back(d);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        axs.tready = 1'b0;
        pix.valid  = 1'b0;
        pix.sof    = 1'b0;
        pix.rgb    = '0;
        repeat (2) @(posedge clk);
        #1;
        armed = 1'b1;
        chk("rst_tvalid", 32'(axs.tvalid), 32'd0);
        chk("rst_tdata", axs.tdata, 32'd0);
        chk("rst_tuser", 32'(axs.tuser), 32'd0);
        chk("rst_tlast", 32'(axs.tlast), 32'd0);
        chk("rst_tkeep", 32'(axs.tkeep), 32'hF);
        chk("rst_ready", 32'(pix.ready), 32'd0);
        rst_n = 1'b1;

        // 1: ascending ramp, tready high
        clr_cnt();
        rdy_mode = 0;
        push_ramp();
        run_idle(500);
        chk("t1_words", 32'(n_words), 32'd12);
        chk("t1_word0", first_word, 32'h03020100);
        chk("t1_tuser", 32'(n_tuser), 32'd1);
        chk("t1_fdone", 32'(n_fd), 32'd1);

        // 2: same ramp, tready toggling
        clr_cnt();
        rdy_mode = 1;
        push_ramp();
        run_idle(500);
        chk("t2_words", 32'(n_words), 32'd12);
        chk("t2_word0", first_word, 32'h03020100);
        chk("t2_fdone", 32'(n_fd), 32'd1);

        // 3: stall with a pending word in P2
        clr_cnt();
        gaps = 1'b0;
        rdy_mode = 3;
        push_rand(16, 1'b1);
        repeat (6) step();
        chk("t3_stall_ready", 32'(pix.ready), 32'd0);
        chk("t3_stall_tvalid", 32'(axs.tvalid), 32'd1);
        chk("t3_stall_taken", 32'(pq.size()), 32'd14);
        rdy_mode = 0;
        gaps = 1'b1;
        run_idle(500);
        chk("t3_words", 32'(n_words), 32'd12);

        // 4: sof on pixel 6 of line 0
        clr_cnt();
        rdy_mode = 2;
        push_rand(6, 1'b1);
        push_rand(16, 1'b1);
        run_idle(1000);
        chk("t4_err", 32'(n_err), 32'd1);
        chk("t4_words", 32'(n_words), 32'd16);
        chk("t4_tuser", 32'(n_tuser), 32'd2);
        chk("t4_fdone", 32'(n_fd), 32'd1);

        // 5: reset mid-line while a word is pending and stalled
        clr_cnt();
        gaps = 1'b0;
        rdy_mode = 3;
        push_rand(3, 1'b1);
        repeat (6) step();
        chk("t5_pending", 32'(axs.tvalid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b0;
        pq.delete();
        pix.valid = 1'b0;
        pix.sof   = 1'b0;
        rst_n = 1'b1;
        chk("t5_rst_tvalid", 32'(axs.tvalid), 32'd0);
        clr_cnt();
        rdy_mode = 0;
        gaps = 1'b1;
        push_rand(16, 1'b0);
        run_idle(500);
        chk("t5_words", 32'(n_words), 32'd12);
        chk("t5_tuser", 32'(n_tuser), 32'd1);
        chk("t5_fdone", 32'(n_fd), 32'd1);

        // 6: three frames, random tready
        clr_cnt();
        rdy_mode = 2;
        push_rand(48, 1'b1);
        run_idle(3000);
        chk("t6_fdone", 32'(n_fd), 32'd3);
        chk("t6_tuser", 32'(n_tuser), 32'd3);
        chk("t6_err", 32'(n_err), 32'd0);
        chk("t6_words", 32'(n_words), 32'd36);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
